// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline-side signal bundle for the hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if;
  logic [31:0] ifid_inst_i;
  logic [31:0] idex_inst_i;
  logic        idex_MemToReg_i;
  logic        idex_RegWrite_i;
  logic        idex_IsBranch_i;
  logic        idex_IsJump_i;
  logic        branch_taken_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        idex_bubble_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output ifid_inst_i, idex_inst_i, idex_MemToReg_i, idex_RegWrite_i,
           idex_IsBranch_i, idex_IsJump_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
           idex_flush_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ifid_inst_i, idex_inst_i, idex_MemToReg_i, idex_RegWrite_i,
           idex_IsBranch_i, idex_IsJump_i, branch_taken_i,
    output pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
           idex_flush_o, stall_cnt_o, flush_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl : load-use stall and taken-branch/jump flush controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  wire            clk_i,
  input  wire            rst_i,
  hazard_ctrl_if.slave   hz
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [3:0] C_STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit         C_MULTI_CYCLE  = (LOAD_STALL_CYCLES > 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  stall_left_q, stall_left_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] ifid_op;
  logic [4:0] ifid_rs, ifid_rt, ld_dst;
  logic       uses_rt, load_use, ctrl_haz;

  always_comb begin
    ifid_op = hz.ifid_inst_i[31:26];
    ifid_rs = hz.ifid_inst_i[25:21];
    ifid_rt = hz.ifid_inst_i[20:16];
    ld_dst  = hz.idex_inst_i[20:16];
    // Only R-type, sw and beq read rt as a source operand
    uses_rt = (ifid_op == 6'h00) || (ifid_op == 6'h2B) || (ifid_op == 6'h04);
    load_use = hz.idex_MemToReg_i && hz.idex_RegWrite_i && (ld_dst != 5'd0) &&
               ((ld_dst == ifid_rs) || (uses_rt && (ld_dst == ifid_rt)));
    ctrl_haz = hz.idex_IsJump_i || (hz.idex_IsBranch_i && hz.branch_taken_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      stall_left_q <= 4'd0;
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (ctrl_haz) begin
      // A redirect kills whatever the stall was protecting
      state_d      = RUN;
      stall_left_d = 4'd0;
      flush_cnt_d  = flush_cnt_q + 32'd1;
    end else if (state_q == STALL) begin
      stall_cnt_d  = stall_cnt_q + 32'd1;
      stall_left_d = stall_left_q - 4'd1;
      if (stall_left_q == 4'd1) begin
        state_d = RUN;
      end
    end else if (load_use) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
      if (C_MULTI_CYCLE) begin
        state_d      = STALL;
        stall_left_d = C_STALL_RELOAD;
      end
    end
  end

  always_comb begin
    hz.pc_write_o    = 1'b1;
    hz.ifid_write_o  = 1'b1;
    hz.idex_bubble_o = 1'b0;
    hz.ifid_flush_o  = 1'b0;
    hz.idex_flush_o  = 1'b0;
    if (!rst_i) begin
      if (ctrl_haz) begin
        hz.ifid_flush_o = 1'b1;
        hz.idex_flush_o = 1'b1;
      end else if ((state_q == STALL) || load_use) begin
        hz.pc_write_o    = 1'b0;
        hz.ifid_write_o  = 1'b0;
        hz.idex_bubble_o = 1'b1;
      end
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : directed checks of hazard_ctrl with 1- and 3-cycle loads
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz1 ();
  hazard_ctrl_if hz3 ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .hz(hz1.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .hz(hz3.slave));

  // Ctrl vector order: {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00100;
  localparam logic [4:0] C_FLUSH = 5'b11011;

  localparam logic [31:0] I_ADD_3   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_435 = {6'h00, 5'd3, 5'd5, 5'd4, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_425 = {6'h00, 5'd2, 5'd5, 5'd4, 5'd0, 6'h20};
  localparam logic [31:0] I_ADD_400 = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20};
  localparam logic [31:0] I_LW_2    = {6'h23, 5'd1, 5'd2, 16'h0000};
  localparam logic [31:0] I_LW_7    = {6'h23, 5'd1, 5'd7, 16'h0000};
  localparam logic [31:0] I_LW_0    = {6'h23, 5'd1, 5'd0, 16'h0000};
  localparam logic [31:0] I_SW_7    = {6'h2B, 5'd1, 5'd7, 16'h0000};
  localparam logic [31:0] I_BEQ     = {6'h04, 5'd8, 5'd9, 16'h0004};

  task automatic drive(input logic [31:0] ifid, input logic [31:0] idex,
                       input logic mem, input logic rw, input logic br,
                       input logic jmp, input logic tkn);
    hz1.ifid_inst_i = ifid;  hz3.ifid_inst_i = ifid;
    hz1.idex_inst_i = idex;  hz3.idex_inst_i = idex;
    hz1.idex_MemToReg_i = mem; hz3.idex_MemToReg_i = mem;
    hz1.idex_RegWrite_i = rw;  hz3.idex_RegWrite_i = rw;
    hz1.idex_IsBranch_i = br;  hz3.idex_IsBranch_i = br;
    hz1.idex_IsJump_i = jmp;   hz3.idex_IsJump_i = jmp;
    hz1.branch_taken_i = tkn;  hz3.branch_taken_i = tkn;
  endtask

  task automatic neutral();
    drive(I_ADD_435, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks combinational controls and counters of both instances
  task automatic chk_all(input string tag, input logic [4:0] c1, input logic [4:0] c3,
                         input logic [31:0] s1, input logic [31:0] f1,
                         input logic [31:0] s3, input logic [31:0] f3);
    #1;
    chk({tag, ".ctrl1"}, {27'd0, hz1.pc_write_o, hz1.ifid_write_o, hz1.idex_bubble_o,
                          hz1.ifid_flush_o, hz1.idex_flush_o}, {27'd0, c1});
    chk({tag, ".ctrl3"}, {27'd0, hz3.pc_write_o, hz3.ifid_write_o, hz3.idex_bubble_o,
                          hz3.ifid_flush_o, hz3.idex_flush_o}, {27'd0, c3});
    chk({tag, ".stall1"}, hz1.stall_cnt_o, s1);
    chk({tag, ".flush1"}, hz1.flush_cnt_o, f1);
    chk({tag, ".stall3"}, hz3.stall_cnt_o, s3);
    chk({tag, ".flush3"}, hz3.flush_cnt_o, f3);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with a hazard on the inputs: controls must stay quiescent
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    chk("rst_quiet.ctrl1", {27'd0, hz1.pc_write_o, hz1.ifid_write_o, hz1.idex_bubble_o,
                            hz1.ifid_flush_o, hz1.idex_flush_o}, {27'd0, C_RUN});
    cyc();
    cyc();
    chk_all("rst", C_RUN, C_RUN, 0, 0, 0, 0);
    rst = 1'b0;

    // No hazard
    drive(I_ADD_435, I_ADD_3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("nohaz", C_RUN, C_RUN, 0, 0, 0, 0);
    cyc();
    chk_all("nohaz_after", C_RUN, C_RUN, 0, 0, 0, 0);

    // Load-use on rs
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("lu_rs", C_STALL, C_STALL, 0, 0, 0, 0);
    cyc();
    neutral();
    chk_all("lu_rs_c1", C_RUN, C_STALL, 1, 0, 1, 0);
    cyc();
    chk_all("lu_rs_c2", C_RUN, C_STALL, 1, 0, 2, 0);
    cyc();
    chk_all("lu_rs_c3", C_RUN, C_RUN, 1, 0, 3, 0);

    // Load-use through sw rt
    drive(I_SW_7, I_LW_7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("lu_sw", C_STALL, C_STALL, 1, 0, 3, 0);
    cyc();
    neutral();
    chk_all("lu_sw_c1", C_RUN, C_STALL, 2, 0, 4, 0);
    cyc();
    chk_all("lu_sw_c2", C_RUN, C_STALL, 2, 0, 5, 0);
    cyc();
    chk_all("lu_sw_c3", C_RUN, C_RUN, 2, 0, 6, 0);

    // lw in IF/ID does not read rt
    drive(I_LW_7, I_LW_7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("lw_rt_ignored", C_RUN, C_RUN, 2, 0, 6, 0);
    cyc();

    // Load to $0 never stalls
    drive(I_ADD_400, I_LW_0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("ld_r0", C_RUN, C_RUN, 2, 0, 6, 0);
    cyc();

    // Branch taken / not taken / taken without IsBranch
    drive(I_ADD_435, I_BEQ, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_all("br_taken", C_FLUSH, C_FLUSH, 2, 0, 6, 0);
    cyc();
    drive(I_ADD_435, I_BEQ, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("br_not_taken", C_RUN, C_RUN, 2, 1, 6, 1);
    cyc();
    drive(I_ADD_435, I_ADD_3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_all("tkn_no_br", C_RUN, C_RUN, 2, 1, 6, 1);
    cyc();

    // Jump coincident with load-use: flush only
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("jmp_lu", C_FLUSH, C_FLUSH, 2, 1, 6, 1);
    cyc();
    neutral();
    chk_all("jmp_lu_after", C_RUN, C_RUN, 2, 2, 6, 2);

    // Jump while the 3-cycle instance is mid-stall
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(I_ADD_435, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("jmp_in_stall", C_FLUSH, C_FLUSH, 3, 2, 7, 2);
    cyc();
    neutral();
    chk_all("jmp_in_stall_after", C_RUN, C_RUN, 3, 3, 7, 3);

    // Reset during stall
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    neutral();
    chk_all("pre_rst_stall", C_RUN, C_STALL, 4, 3, 8, 3);
    rst = 1'b1;
    chk_all("rst_in_stall", C_RUN, C_RUN, 4, 3, 8, 3);
    cyc();
    rst = 1'b0;
    chk_all("rst_in_stall_after", C_RUN, C_RUN, 0, 0, 0, 0);
    cyc();
    chk_all("rst_release", C_RUN, C_RUN, 0, 0, 0, 0);

    // Counter wrap
    drive(I_ADD_425, I_LW_2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    force u_dut1.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut1.stall_cnt_q;
    #1;
    chk("wrap_pre", hz1.stall_cnt_o, 32'hFFFF_FFFF);
    cyc();
    neutral();
    #1;
    chk("wrap_post", hz1.stall_cnt_o, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller sitting alongside the ID/EX pipeline register. It consumes the ID/EX stage contents (instruction, load/branch/jump controls) and the IF/ID instruction. It drives the stall, bubble and flush controls back into PC, IF/ID and ID/EX. It resolves load-use data hazards, including a configurable multi-cycle data-memory latency, and taken-branch/jump control hazards, and keeps stall and flush event counters.

## Interface
- LOAD_STALL_CYCLES, 1: bubble cycles inserted per load-use hazard; legal range 1..15.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ifid_inst_i  in  32  instruction currently in IF/ID (decode stage).
- idex_inst_i  in  32  instruction currently in ID/EX (execute stage).
- idex_MemToReg_i  in  1  ID/EX instruction is a load.
- idex_RegWrite_i  in  1  ID/EX instruction writes the register file.
- idex_IsBranch_i  in  1  ID/EX instruction is a conditional branch.
- idex_IsJump_i  in  1  ID/EX instruction is a jump.
- branch_taken_i  in  1  EX-stage branch condition true; meaningful only with idex_IsBranch_i.
- pc_write_o  out  1  1 = PC may update; 0 = hold PC.
- ifid_write_o  out  1  1 = IF/ID may load; 0 = hold IF/ID.
- idex_bubble_o  out  1  1 = ID/EX loads all-zero controls (NOP) this edge.
- ifid_flush_o  out  1  1 = IF/ID loads a zero instruction this edge.
- idex_flush_o  out  1  1 = ID/EX loads zero instruction and zero controls this edge.
- stall_cnt_o  out  32  registered count of stall cycles.
- flush_cnt_o  out  32  registered count of flush events.

## Operation
- Field extraction: opcode = [31:26], rs = [25:21], rt = [20:16].
- Load destination: ld_dst = idex_inst_i[20:16].
- IF/ID uses rt only when ifid opcode is 6'h00 (R-type), 6'h2B (sw) or 6'h04 (beq); otherwise rt is not compared.
- load_use = idex_MemToReg_i & idex_RegWrite_i & (ld_dst != 0) & ((ld_dst == ifid rs) | (uses_rt & ld_dst == ifid rt)).
- ctrl_haz = idex_IsJump_i | (idex_IsBranch_i & branch_taken_i).
- FSM states: RUN, STALL. A down-counter stall_left (4 bits) is valid in STALL.
- In RUN with ctrl_haz: ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, ifid_write_o=1, idex_bubble_o=0. Stay in RUN. flush_cnt increments by 1.
- In RUN with load_use and no ctrl_haz: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. stall_cnt increments by 1.
  - If LOAD_STALL_CYCLES > 1: go to STALL with stall_left = LOAD_STALL_CYCLES-1.
  - Otherwise stay in RUN.
- In RUN with neither hazard: pc_write_o=1, ifid_write_o=1, all bubble/flush outputs 0.
- In STALL: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, stall_cnt increments by 1, stall_left decrements. When stall_left == 1, the next state is RUN.
- Hazard priority: ctrl_haz overrides load_use in any state. In STALL, ctrl_haz forces the flush outputs, aborts the stall, and returns to RUN; flush_cnt increments and stall_cnt does not.
- Counters wrap modulo 2^32 with no saturation.

## Timing
- Control outputs are combinational from the current inputs plus registered state. They take effect at the same rising edge as the pipeline registers they steer, so there is zero added latency.
- FSM state, stall_left and both counters update on the rising edge. stall_cnt_o and flush_cnt_o reflect events up to and including the previous cycle.
- Each load-use hazard holds PC and IF/ID for exactly LOAD_STALL_CYCLES edges, then releases.
- While rst_i=1:
  - pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, ifid_flush_o=0, idex_flush_o=0, regardless of inputs.
  - On the next edge: state=RUN, stall_left=0, stall_cnt_o=0, flush_cnt_o=0.
- Reset asserted mid-STALL abandons the stall immediately, and no counter increments on that edge.
- A flush and a bubble are never both asserted in the same cycle.

## Test plan
- No hazard: LOAD_STALL_CYCLES=1, ID/EX add $3 and IF/ID add $4,$3,$5 -> pc_write_o=1, no bubble/flush, counters stay 0.
- Load-use: ID/EX lw $2 and IF/ID add $4,$2,$5 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, then resume; stall_cnt_o=1.
- Multi-cycle: LOAD_STALL_CYCLES=3 with lw $7 then sw $7 (rt match) -> exactly 3 stall cycles, then RUN; stall_cnt_o=3. Load to $0 -> no stall.
- Control hazard: idex_IsBranch_i=1 with branch_taken_i=1 -> ifid_flush_o=idex_flush_o=1 for one cycle, flush_cnt_o=1. With branch_taken_i=0 -> no flush.
- Priority and reset: jump coincident with load_use -> flush only, no stall. rst_i=1 during STALL -> outputs quiescent, counters 0, RUN next cycle.
- Wrap: preload stall_cnt to 32'hFFFFFFFF through a bench force, then one stall -> stall_cnt_o=0.
